// File: rtl/expr_pipe_pkg.sv
// Shared defaults for the expression pipeline: operand/intermediate/result widths,
// step constants and the number of register stages.
package expr_pipe_pkg;

    localparam int              DEF_DATA_W = 4;
    localparam int              DEF_MID_W  = 16;
    localparam int              DEF_OUT_W  = 10;
    localparam logic [3:0]      DEF_K0     = 4'h5;
    localparam logic [15:0]     DEF_K1     = 16'd1000;
    localparam int              NUM_STAGES = 3;

endpackage

// File: rtl/expr_pipe_stage.sv
// Generic valid/ready register slice: one payload register plus a valid bit,
// with synchronous flush and asynchronous active-high reset.
module expr_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // An empty slot accepts even while downstream is stalled, so bubbles fill up.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/expr_pipe_datapath.sv
// Three-stage pipelined expression datapath: out = (t1 ^ (t1>>3)) - t0 with
// t0 = x + (x ^ K0), t1 = t0*t0 + K1. Define EXPR_PIPE_CHKSUM_EN to add chk_o.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high;
// valid never depends on ready, while in_ready is combinational from out_ready.
module expr_pipe_datapath
    import expr_pipe_pkg::*;
#(
    parameter int                DATA_W = DEF_DATA_W,
    parameter int                MID_W  = DEF_MID_W,
    parameter int                OUT_W  = DEF_OUT_W,
    parameter logic [DATA_W-1:0] K0     = DATA_W'(DEF_K0),
    parameter logic [MID_W-1:0]  K1     = MID_W'(DEF_K1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data
`ifdef EXPR_PIPE_CHKSUM_EN
    ,
    output logic [OUT_W-1:0]  chk_o
`endif
);

    localparam int T0_W   = DATA_W + 1;
    localparam int S2_W   = T0_W + MID_W;
    localparam int CALC_W = (MID_W > OUT_W) ? MID_W : OUT_W;

    logic [NUM_STAGES:1]   w_v;
    logic [NUM_STAGES+1:1] w_rdy;

    logic [T0_W-1:0]  w_t0_next;
    logic [T0_W-1:0]  w_t0_s1;
    logic [MID_W-1:0] w_t1_next;
    logic [S2_W-1:0]  w_s2_next;
    logic [S2_W-1:0]  w_s2_q;
    logic [T0_W-1:0]  w_t0_s2;
    logic [MID_W-1:0] w_t1_s2;
    logic [MID_W-1:0] w_mix;
    logic [OUT_W-1:0] w_out_next;

    assign w_rdy[NUM_STAGES+1] = out_ready;
    assign in_ready            = w_rdy[1];
    assign out_valid           = w_v[NUM_STAGES];

    // Step 1: widen before adding so the carry out of DATA_W bits is kept.
    assign w_t0_next = T0_W'(in_data) + T0_W'(in_data ^ K0);

    expr_pipe_stage #(.W(T0_W)) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush_i),
        .i_valid (in_valid),
        .o_ready (w_rdy[1]),
        .i_data  (w_t0_next),
        .o_valid (w_v[1]),
        .i_ready (w_rdy[2]),
        .o_data  (w_t0_s1)
    );

    // Step 2: t0 is carried alongside t1 because step 3 subtracts it.
    assign w_t1_next = MID_W'(w_t0_s1) * MID_W'(w_t0_s1) + K1;
    assign w_s2_next = {w_t0_s1, w_t1_next};

    expr_pipe_stage #(.W(S2_W)) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush_i),
        .i_valid (w_v[1]),
        .o_ready (w_rdy[2]),
        .i_data  (w_s2_next),
        .o_valid (w_v[2]),
        .i_ready (w_rdy[3]),
        .o_data  (w_s2_q)
    );

    assign w_t0_s2    = w_s2_q[S2_W-1:MID_W];
    assign w_t1_s2    = w_s2_q[MID_W-1:0];
    assign w_mix      = w_t1_s2 ^ (w_t1_s2 >> 3);
    assign w_out_next = OUT_W'(CALC_W'(w_mix) - CALC_W'(w_t0_s2));

    expr_pipe_stage #(.W(OUT_W)) u_s3 (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush_i),
        .i_valid (w_v[2]),
        .o_ready (w_rdy[3]),
        .i_data  (w_out_next),
        .o_valid (w_v[3]),
        .i_ready (w_rdy[4]),
        .o_data  (out_data)
    );

`ifdef EXPR_PIPE_CHKSUM_EN
    logic [OUT_W-1:0] r_chk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk <= '0;
        end else if (flush_i) begin
            r_chk <= '0;
        end else if (out_valid && out_ready) begin
            r_chk <= r_chk ^ out_data;
        end
    end

    assign chk_o = r_chk;
`endif

endmodule

// File: tb/tb_expr_pipe_datapath.sv
// Self-checking bench for expr_pipe_datapath: directed latency/stream/stall/reset/flush
// cases plus a random stream, all results checked against a reference model queue.
module tb_expr_pipe_datapath;

    localparam int DATA_W = 4;
    localparam int MID_W  = 16;
    localparam int OUT_W  = 10;
    localparam logic [DATA_W-1:0] K0 = 4'h5;
    localparam int K1 = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_i;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
`ifdef EXPR_PIPE_CHKSUM_EN
    logic [OUT_W-1:0]  chk_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] exp_chk = '0;

    expr_pipe_datapath dut (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef EXPR_PIPE_CHKSUM_EN
        ,
        .chk_o     (chk_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] model(input logic [DATA_W-1:0] x);
        int t0;
        int t1;
        int r;
        t0 = (int'(x) + int'(x ^ K0)) % (1 << (DATA_W + 1));
        t1 = (t0 * t0 + K1) % (1 << MID_W);
        r  = (t1 ^ (t1 >> 3)) - t0;
        return r[OUT_W-1:0];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sampled mid-cycle, so the handshakes seen here complete at the next edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_chk <= '0;
        end else begin
            if (out_valid && out_ready) begin
                check_eq("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check_eq("sb_data", 32'(out_data), 32'(exp_q[0]));
                    exp_chk <= exp_chk ^ exp_q[0];
                    void'(exp_q.pop_front());
                end
            end
            if (flush_i) begin
                exp_q.delete();
                exp_chk <= '0;
            end else if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data));
            end
        end
    end

    task automatic run_single(input logic [DATA_W-1:0] x, input logic [OUT_W-1:0] exp,
                              input string tag);
        int lat;
        in_valid = 1'b1;
        in_data  = x;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd3);
        check_eq({tag, "_data"}, 32'(out_data), 32'(exp));
        step();
    endtask

    task automatic drain();
        int budget;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            step();
            budget++;
        end
        step();
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
        check_eq("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    logic [DATA_W-1:0] stream_x[3]   = '{4'd0, 4'd3, 4'd15};
    logic [OUT_W-1:0]  stream_exp[3] = '{10'd124, 10'd181, 10'd633};
    logic [DATA_W-1:0] bp_x[4]       = '{4'd1, 4'd6, 4'd11, 4'd14};

    initial begin
        rst       = 1'b1;
        flush_i   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef EXPR_PIPE_CHKSUM_EN
        check_eq("rst_chk", 32'(chk_o), 32'd0);
`endif
        step();
        rst = 1'b0;
        step();

        run_single(4'd3, 10'd181, "single_x3");

        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = stream_x[i];
            check_eq("stream_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("stream_out_valid", 32'(out_valid), 32'd1);
            check_eq("stream_out_data", 32'(out_data), 32'(stream_exp[i]));
            step();
        end
        check_eq("stream_idle", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = bp_x[i];
            check_eq("bp_in_ready", 32'(in_ready), 32'(i < 3));
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
            check_eq("bp_hold_data", 32'(out_data), 32'(model(bp_x[0])));
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_release_valid", 32'(out_valid), 32'd1);
            check_eq("bp_release_data", 32'(out_data), 32'(model(bp_x[i])));
            step();
        end
        check_eq("bp_empty", 32'(out_valid), 32'd0);

        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i + 2);
            step();
        end
        #3;
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("async_rst_out_data", 32'(out_data), 32'd0);
        check_eq("async_rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();

        in_valid = 1'b1;
        in_data  = 4'd1;
        step();
        in_data  = 4'd2;
        step();
        flush_i  = 1'b1;
        in_data  = 4'd7;
        check_eq("flush_in_ready", 32'(in_ready), 32'd1);
        step();
        flush_i  = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("flush_no_output", 32'(out_valid), 32'd0);
            step();
        end
        run_single(4'd9, model(4'd9), "post_flush_x9");

`ifdef EXPR_PIPE_CHKSUM_EN
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check_eq("chk_after_flush0", 32'(chk_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = stream_x[i];
            step();
        end
        drain();
        check_eq("chk_stream", 32'(chk_o), 32'(exp_chk));
        check_eq("chk_stream_nonzero", 32'(chk_o != 0), 32'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check_eq("chk_after_flush", 32'(chk_o), 32'd0);
`endif

        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
